// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data-port initiator.
// Op codes, FSM states, alignment check and byte-lane mask.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } lsu_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } lsu_state_t;

    function automatic logic is_store(lsu_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(lsu_op_t op, logic [1:0] a);
        logic m;
        unique case (op)
            OP_LH, OP_LHU, OP_SH: m = a[0];
            OP_LW, OP_SW:         m = (a != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_be(lsu_op_t op, logic [1:0] a);
        logic [3:0] be;
        unique case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
            default:              be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byteenable, store replication, load extraction.
// Ports: op/lane select, wdata in, dp_data in; byteenable, writedata, load_data out.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] dp_data,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        byteenable = lane_be(op, lane);
        b = 8'(dp_data >> {lane, 3'b000});
        h = lane[1] ? dp_data[31:16] : dp_data[15:0];

        writedata = 32'h0;
        unique case (op)
            OP_SB:   writedata = {4{wdata[7:0]}};
            OP_SH:   writedata = {2{wdata[15:0]}};
            OP_SW:   writedata = wdata;
            default: writedata = 32'h0;
        endcase

        load_data = dp_data;
        unique case (op)
            OP_LB:   load_data = {{24{b[7]}}, b};
            OP_LBU:  load_data = {24'h0, b};
            OP_LH:   load_data = {{16{h[15]}}, h};
            OP_LHU:  load_data = {16'h0, h};
            default: load_data = dp_data;
        endcase
    end

endmodule

// File: rtl/lsu_dp_master.sv
// Load/store initiator: one request -> one word-aligned data-port access.
// Ports: clk/rst, CPU req/op/addr/wdata -> busy/done/err/rdata; data-port master side.
module lsu_dp_master
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] dp_address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        read_dp,
    output logic        write_dp,
    input  logic [31:0] dp_data,
    input  logic        stall
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    lsu_state_t  state, state_d;
    lsu_op_t     op_in, op_q, op_d, al_op;
    logic [1:0]  lane_q, lane_d, al_lane;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  al_be, be_d;
    logic [31:0] al_wd, al_ld, wd_d, addr_d, rdata_d;
    logic        done_d, err_d, rd_d, wr_d;

    assign op_in = lsu_op_t'(op);

    // One lane unit serves both phases: request fields while idle
    // (issue), latched fields while accessing (load formatting).
    assign al_op   = (state == ST_IDLE) ? op_in : op_q;
    assign al_lane = (state == ST_IDLE) ? addr[1:0] : lane_q;

    lsu_lane_align u_align (
        .op         (al_op),
        .lane       (al_lane),
        .wdata      (wdata),
        .dp_data    (dp_data),
        .byteenable (al_be),
        .writedata  (al_wd),
        .load_data  (al_ld)
    );

    always_comb begin
        state_d = state;
        wait_d  = wait_q;
        op_d    = op_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata;
        addr_d  = dp_address;
        wd_d    = writedata;
        be_d    = byteenable;
        rd_d    = read_dp;
        wr_d    = write_dp;

        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned(op_in, addr[1:0])) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        wait_d  = 8'd0;
                        op_d    = op_in;
                        lane_d  = addr[1:0];
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = al_be;
                        wd_d    = al_wd;
                        rd_d    = !is_store(op_in);
                        wr_d    = is_store(op_in);
                    end
                end
            end
            ST_ACCESS: begin
                if (!stall || wait_q == MAX_W) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = stall;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    wd_d    = 32'h0;
                    be_d    = 4'b0000;
                    if (!stall && !is_store(op_q))
                        rdata_d = al_ld;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q     <= 8'd0;
            op_q       <= OP_LB;
            lane_q     <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= 32'h0;
            dp_address <= 32'h0;
            writedata  <= 32'h0;
            byteenable <= 4'b0000;
            read_dp    <= 1'b0;
            write_dp   <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            busy       <= (state_d == ST_ACCESS);
            done       <= done_d;
            err        <= err_d;
            rdata      <= rdata_d;
            dp_address <= addr_d;
            writedata  <= wd_d;
            byteenable <= be_d;
            read_dp    <= rd_d;
            write_dp   <= wr_d;
        end
    end

endmodule

// File: tb/tb_lsu_dp_master.sv
// Self-checking bench for lsu_dp_master with a stall-programmable stub memory.
// Directed cases plus random ops checked against an arithmetic reference model.
module tb_lsu_dp_master;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, read_dp, write_dp;
    logic [31:0] rdata, dp_address, writedata, dp_data;
    logic [3:0]  byteenable;
    logic        stall = 1'b0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    lsu_dp_master #(.MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .dp_address (dp_address),
        .writedata  (writedata),
        .byteenable (byteenable),
        .read_dp    (read_dp),
        .write_dp   (write_dp),
        .dp_data    (dp_data),
        .stall      (stall)
    );

    assign dp_data = read_dp ? mem[dp_address[5:2]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (write_dp && !stall)
            for (int i = 0; i < 4; i++)
                if (byteenable[i])
                    mem[dp_address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1 || o == 3'd5) return 1;
        if (o == 3'd2 || o == 3'd3 || o == 3'd6) return 2;
        return 4;
    endfunction

    task automatic run(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd, input int ns, input bit extra);
        int sz, lat, strobes, elat, estr;
        bit st, mis, tmo, got_done;
        logic [31:0] e_be, e_wd, word, v, mask;
        sz  = op_size(o);
        st  = (o >= 3'd5);
        mis = (a % sz) != 0;
        tmo = !mis && ns > MW;
        e_be = ((32'd1 << sz) - 1) << a[1:0];
        if (sz == 1)      e_wd = wd[7:0] * 32'h01010101;
        else if (sz == 2) e_wd = wd[15:0] * 32'h00010001;
        else              e_wd = wd;

        @(negedge clk);
        chk("done_pulse", {31'h0, done}, 0);
        req = 1'b1; op = o; addr = a; wdata = wd;
        got_done = 0; strobes = 0; lat = 0;
        for (int k = 1; k <= 40 && !got_done; k++) begin
            @(negedge clk);
            req = extra && k == 1;
            if (req) begin op = 3'd7; addr = 32'h20; end
            if (done) begin
                got_done = 1;
                lat = k;
            end else begin
                if (read_dp || write_dp) begin
                    strobes++;
                    chk("dp_address", dp_address, {a[31:2], 2'b00});
                    chk("byteenable", {28'h0, byteenable}, e_be);
                    chk("read_dp", {31'h0, read_dp}, {31'h0, !st});
                    chk("write_dp", {31'h0, write_dp}, {31'h0, st});
                    chk("writedata", writedata, st ? e_wd : 32'h0);
                    chk("busy", {31'h0, busy}, 1);
                end
                stall = (k - 1) < ns;
            end
        end
        stall = 1'b0;
        req = 1'b0;
        if (!got_done) chk("done_seen", 0, 1);

        if (mis)      begin elat = 1;      estr = 0;      end
        else if (tmo) begin elat = MW + 2; estr = MW + 1; end
        else          begin elat = ns + 2; estr = ns + 1; end

        if (!mis && !tmo) begin
            word = ref_mem[a[5:2]];
            if (st) begin
                mask = 0;
                for (int i = 0; i < 4; i++)
                    if (e_be[i]) mask = mask | (32'hFF << (8 * i));
                ref_mem[a[5:2]] = (word & ~mask) | (e_wd & mask);
            end else if (sz == 1) begin
                v = (word >> (8 * a[1:0])) & 32'hFF;
                exp_rdata = (o == 3'd0 && v >= 128) ? (v | 32'hFFFFFF00) : v;
            end else if (sz == 2) begin
                v = (word >> (16 * a[1])) & 32'hFFFF;
                exp_rdata = (o == 3'd2 && v >= 32768) ? (v | 32'hFFFF0000) : v;
            end else begin
                exp_rdata = word;
            end
        end
        chk("latency", lat, elat);
        chk("strobes", strobes, estr);
        chk("err", {31'h0, err}, {31'h0, mis || tmo});
        chk("rdata", rdata, exp_rdata);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        mem[i] = w;
        ref_mem[i] = w;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        exp_rdata = 32'h0;
        #12;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_strobe", {30'h0, read_dp, write_dp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", dp_address, 0);
        chk("rst_wd", writedata, 0);
        chk("rst_be", {28'h0, byteenable}, 0);
        @(negedge clk);
        rst = 1'b0;

        set_word(4, 32'h8899AABB);
        run(3'd4, 32'h10, 0, 0, 0);
        set_word(4, 32'h80112233);
        run(3'd0, 32'h13, 0, 0, 0);
        run(3'd1, 32'h13, 0, 0, 0);
        run(3'd2, 32'h12, 0, 0, 0);
        run(3'd5, 32'h05, 32'h000000A5, 0, 0);
        run(3'd6, 32'h06, 32'h00001234, 0, 0);
        run(3'd4, 32'h04, 0, 0, 0);
        run(3'd4, 32'h10, 0, 3, 1);
        run(3'd2, 32'h01, 0, 0, 0);
        run(3'd4, 32'h14, 0, 100, 0);

        @(negedge clk);
        req = 1'b1; op = 3'd4; addr = 32'h10;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) req = 1'b0;
            chk("b2b_done", {31'h0, done}, {31'h0, k == 2 || k == 4});
            if (k == 2 || k == 4) chk("b2b_rdata", rdata, ref_mem[4]);
        end
        exp_rdata = ref_mem[4];

        @(negedge clk);
        req = 1'b1; op = 3'd4; addr = 32'h18;
        @(negedge clk);
        req = 1'b0; stall = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobe", {31'h0, read_dp}, 0);
        chk("rst_mid_busy", {31'h0, busy}, 0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        exp_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", {31'h0, done}, 0);
        end
        chk("rst_mid_rdata", rdata, 0);

        for (int n = 0; n < 80; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            int          rs;
            ro = 3'($urandom_range(0, 7));
            ra = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
            rs = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
            run(ro, ra, $urandom, rs, rs >= 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_dp_master.md
# lsu_dp_master

Load/store initiator for the data port of the Harvard memory. It accepts one MIPS load/store request at a time from the CPU execute/memory stage and converts it into a single word-aligned data-port transaction with the correct byteenable. It waits out `stall`, then returns the extracted, sign- or zero-extended load result together with a one-cycle `done` pulse. It sits between the CPU datapath and the data port of `mem_harvard`, and is the requesting end of that port.

## Interface
- `MAX_WAIT`, default 255: number of consecutive stalled ACCESS cycles tolerated before the transaction is aborted with `err`. Legal range is 1..255.

- `clk` in 1: the single clock; every register samples on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request strobe. It is sampled only while `busy`=0.
- `op` in 3: operation code. 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- `addr` in 32: byte address.
- `wdata` in 32: store data; the value is right-justified.
- `busy` out 1: a transaction is in flight.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; the access was misaligned or timed out.
- `rdata` out 32: load result. Valid while `done`=1 and held afterwards.
- `dp_address` out 32: word address, `{addr[31:2],2'b00}`.
- `writedata` out 32: replicated store data.
- `byteenable` out 4: active byte lanes.
- `read_dp` out 1: read strobe.
- `write_dp` out 1: write strobe.
- `dp_data` in 32: read data, valid in any cycle with `read_dp`=1 and `stall`=0.
- `stall` in 1: the memory is not ready; the current strobe must be held.

## Operation
- **Byte lanes:** the byte at `addr[1:0]`=k occupies `dp_data`/`writedata` bits [8k+7:8k] (little-endian lane map).
- **States:** IDLE and ACCESS.
- **IDLE:**
  - `busy`=0.
  - When `req`=1, the block checks alignment:
    - Halfword op with `addr[0]`=1, or word op with `addr[1:0]`≠0: the block stays in IDLE. Next cycle `done`=1, `err`=1, no strobe is issued, and `rdata` is unchanged.
    - Otherwise the block latches `op`, `addr` and `wdata`, then moves to ACCESS.
- **ACCESS:**
  - `busy`=1.
  - Exactly one of `read_dp`/`write_dp` is high.
  - Address, data and byteenable are held stable.
- **Completion:** the first rising edge in ACCESS with `stall`=0.
  - The block returns to IDLE.
  - Next cycle `done`=1 and `err`=0.
  - For loads, `rdata` takes the formatted `dp_data` captured at that edge.
- **Byteenable:**
  - B ops: `1<<addr[1:0]`.
  - H ops: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - W ops: 1111.
  - Loads drive the same pattern as stores.
- **Writedata:** SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`. While not writing, `writedata`=0.
- **Load format:**
  - LB/LH sign-extend the selected lane(s).
  - LBU/LHU zero-extend.
  - LW passes the word through unchanged.
- **Stores:** `rdata` is unchanged on store completion.
- **Timeout:**
  - A wait counter is cleared on entry to ACCESS and increments on every stalled ACCESS cycle.
  - At the edge where the counter equals `MAX_WAIT` and `stall` is still 1: strobes drop, the block enters IDLE, and next cycle `done`=1, `err`=1 with `rdata` unchanged.
- **Requests while busy:** `req` while `busy`=1 is ignored and is not queued.

## Timing
- **Reset values:** `busy`, `done`, `err`, `read_dp`, `write_dp` = 0; `rdata`, `dp_address`, `writedata` = 0; `byteenable` = 0000; state = IDLE; wait counter = 0.
- **Reset mid-ACCESS:** strobes fall asynchronously with `rst`, the in-flight access is discarded, and no `done` is produced.
- **Latency:** `req` is sampled at edge E0 and the strobe is high in cycle E0→E1.
  - With `stall`=0 at E1, `done` is high in cycle E1→E2.
  - Each stalled cycle adds one cycle.
  - Minimum latency is 2 cycles from `req` to `done`.
  - A misaligned request gives `done` one cycle after `req`.
- **Back-to-back requests:** `req` may be asserted in the same cycle as `done`. It is accepted at that edge, giving one transaction per 2 cycles when there is no stall.
- **Outputs:** all outputs come from registers; none is combinational from `req`, `stall` or `dp_data`.
- **Width:** the wait counter is 8 bits.

## Structure
- Package `lsu_pkg` holds:
  - the `op` enum (`lsu_op_t`);
  - the state enum;
  - the `OP_*` constants;
  - a function giving the byteenable for an op and `addr[1:0]`.
- Sub-module `lsu_lane_align`, purely combinational, holds:
  - the byteenable generation;
  - the `writedata` replication;
  - the load lane extraction and extension.
- The FSM, counter and registers live in the top module.

## Test plan
Use a stub responder with programmable stall.

1. **LW, no stall:** LW at `addr`=0x10 with memory word 0x8899AABB → `read_dp` high for 1 cycle, `dp_address`=0x10, `byteenable`=1111; `done` 2 cycles after `req`, `rdata`=0x8899AABB, `err`=0.
2. **Sub-word loads:** LB at 0x13 on word 0x80112233 → `byteenable`=1000, `rdata`=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x12 → 0xFFFF8011.
3. **Sub-word stores:** SB at 0x05 with `wdata`=0x000000A5 → `writedata`=0xA5A5A5A5, `byteenable`=0010. SH at 0x06 with `wdata`=0x1234 → `writedata`=0x12341234, `byteenable`=1100.
4. **Stall:** stall held for 3 cycles on a LW → strobe held 4 cycles with address stable; `done` 5 cycles after `req`; an extra `req` during the stall is ignored.
5. **Misalignment and timeout:** LH at 0x01 → `done`=1 and `err`=1 one cycle later with no strobe. Stall held permanently with `MAX_WAIT`=4 → strobe drops after 5 ACCESS cycles, then `done`=1, `err`=1, `rdata` unchanged.
6. **Reset and back-to-back:** `rst` asserted in the 2nd stalled cycle → strobes 0 immediately, `busy`=0, no `done`. Two back-to-back LW requests → two `done` pulses 2 cycles apart.
